// File: rtl/keypad_digit_ctrl_pkg.sv
// keypad_pkg: shared types and constants for the keypad digit controller.
//   kstate_t     - controller FSM state encoding
//   REPEAT_TICKS - held scan ticks between auto-repeat commits
//   KEY_0..KEY_F - hex codes reported by the 4x4 keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    COMMIT   = 2'd2,
    WAIT_REL = 2'd3
  } kstate_t;

  localparam int REPEAT_TICKS = 200;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

endpackage

// File: rtl/keypad_digit_ctrl_if.sv
// keypad_digit_if: bundle between the keypad scanner / display and the
// digit controller.
//   key_hex, key_valid, key_held : scanner -> controller
//   scan_en                      : controller -> scanner (scan-rate enable)
//   digit_l, digit_r, new_digit  : committed digit history and commit pulse
//   disp_sel, seg_hex            : display multiplex select and shared digit
//   state                        : controller FSM state (debug observation)
// Signalling: key_* are level signals that are only meaningful in a cycle
// where scan_en=1; there is no back-pressure, every tick is consumed.
// modport slave is the controller, modport master is the scanner/display side.
interface keypad_digit_if;
  import keypad_pkg::*;

  logic [3:0] key_hex;
  logic       key_valid;
  logic       key_held;
  logic       scan_en;
  logic [3:0] digit_l;
  logic [3:0] digit_r;
  logic       new_digit;
  logic       disp_sel;
  logic [3:0] seg_hex;
  kstate_t    state;

  modport slave (
    input  key_hex, key_valid, key_held,
    output scan_en, digit_l, digit_r, new_digit, disp_sel, seg_hex, state
  );

  modport master (
    output key_hex, key_valid, key_held,
    input  scan_en, digit_l, digit_r, new_digit, disp_sel, seg_hex, state
  );

endinterface

// File: rtl/keypad_digit_ctrl_tick_divider.sv
// tick_divider: free-running counter 0..DIV-1; tick is high for the one
// cycle in which the count equals DIV-1, after which the count wraps.
//   clk   - clock
//   reset - synchronous active-low reset (count cleared, tick low)
//   tick  - one-cycle enable pulse every DIV cycles
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_digit_ctrl.sv
// keypad_digit_ctrl: paces the keypad scanner, debounces press and release,
// commits each accepted key into a two-digit history (newest on the right)
// and multiplexes the two digits onto one shared segment decoder.
// Ports:
//   clk   - system clock
//   reset - synchronous active-low reset
//   kif   - keypad_digit_if.slave (key inputs, scan_en, digits, mux, state)
// Parameters: SCAN_DIV (clk per scan tick), DB_CNT (ticks to accept press
// and release), MUX_DIV (clk per display-select toggle).
// Build option: define KEYPAD_REPEAT_EN to auto-repeat a held key every
// REPEAT_TICKS held ticks; otherwise a held key commits once.
module keypad_digit_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DB_CNT   = 50,
  parameter int MUX_DIV  = 20000
) (
  input  logic           clk,
  input  logic           reset,
  keypad_digit_if.slave  kif
);

  localparam int CW = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

  logic       scan_tick;
  logic       mux_tick;
  kstate_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] digit_l_q, digit_r_q;
  logic       disp_sel_q;

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .reset (reset),
    .tick  (scan_tick)
  );

  tick_divider #(.DIV(MUX_DIV)) u_mux_div (
    .clk   (clk),
    .reset (reset),
    .tick  (mux_tick)
  );

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_q, rep_d;

  always_ff @(posedge clk) begin
    if (!reset) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (scan_tick && kif.key_valid) begin
          cand_d  = kif.key_hex;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (scan_tick) begin
          if (kif.key_held) begin
            if (cnt_q == CNT_LAST) state_d = COMMIT;
            else                   cnt_d   = cnt_q + 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      COMMIT: begin
        // A tick coinciding with this cycle is deliberately dropped.
        cnt_d   = '0;
        state_d = WAIT_REL;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = '0;
`endif
      end
      WAIT_REL: begin
        if (scan_tick) begin
          if (!kif.key_held) begin
`ifdef KEYPAD_REPEAT_EN
            rep_d = '0;
`endif
            if (cnt_q == CNT_LAST) state_d = IDLE;
            else                   cnt_d   = cnt_q + 1'b1;
          end else begin
            // Any held tick restarts the release debounce.
            cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            if (rep_q == REP_LAST) state_d = COMMIT;
            else                   rep_d   = rep_q + 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Digits shift on the edge that enters COMMIT, so they change together
  // with new_digit rising (new_digit is decoded from the COMMIT state).
  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_l_q <= '0;
      digit_r_q <= '0;
    end else if (state_d == COMMIT && state_q != COMMIT) begin
      digit_l_q <= digit_r_q;
      digit_r_q <= cand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)        disp_sel_q <= 1'b0;
    else if (mux_tick) disp_sel_q <= ~disp_sel_q;
  end

  assign kif.scan_en   = scan_tick;
  assign kif.digit_l   = digit_l_q;
  assign kif.digit_r   = digit_r_q;
  assign kif.new_digit = (state_q == COMMIT);
  assign kif.disp_sel  = disp_sel_q;
  assign kif.seg_hex   = disp_sel_q ? digit_l_q : digit_r_q;
  assign kif.state     = state_q;

endmodule

// File: tb/tb_keypad_digit_ctrl.sv
// Directed testbench for keypad_digit_ctrl with SCAN_DIV=4, DB_CNT=3,
// MUX_DIV=8. Inputs are applied at the falling edge of a scan_en cycle and
// outputs are sampled at falling edges.
module tb_keypad_digit_ctrl;
  import keypad_pkg::*;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  int   pulse_cnt;
  int   base;
  int   exp_pulses;

  keypad_digit_if kif ();

  keypad_digit_ctrl #(.SCAN_DIV(4), .DB_CNT(3), .MUX_DIV(8)) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b1 && kif.new_digit === 1'b1) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one scan tick: wait for a scan_en cycle, apply inputs before its
  // rising edge, return just after that edge.
  task automatic tick_drive(input logic v, input logic [3:0] hex, input logic held);
    int guard;
    guard = 0;
    @(negedge clk);
    while (kif.scan_en !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_assert++;
      n_fail++;
      $error("FAIL tick_timeout: observed no scan_en expected scan_en within 20 cycles");
    end
    kif.key_valid = v;
    kif.key_hex   = hex;
    kif.key_held  = held;
    @(posedge clk);
    #1;
    kif.key_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] hex, input int nheld);
    tick_drive(1'b1, hex, 1'b1);
    for (int i = 0; i < nheld; i++) tick_drive(1'b0, hex, 1'b1);
  endtask

  task automatic release_key(input int n);
    for (int i = 0; i < n; i++) tick_drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic wait_sel(input logic val);
    int guard;
    guard = 0;
    @(negedge clk);
    while (kif.disp_sel !== val && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_assert++;
      n_fail++;
      $error("FAIL sel_timeout: observed no disp_sel=%0d expected within 40 cycles", val);
    end
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    pulse_cnt     = 0;
    reset         = 1'b0;
    kif.key_hex   = 4'h0;
    kif.key_valid = 1'b0;
    kif.key_held  = 1'b0;

    // 1. reset for 5 cycles, then dividers
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_scan_en",   8'(kif.scan_en),   8'h0);
    check("rst_new_digit", 8'(kif.new_digit), 8'h0);
    check("rst_digit_l",   8'(kif.digit_l),   8'h0);
    check("rst_digit_r",   8'(kif.digit_r),   8'h0);
    check("rst_disp_sel",  8'(kif.disp_sel),  8'h0);
    check("rst_seg_hex",   8'(kif.seg_hex),   8'h0);
    check("rst_state",     8'(kif.state),     8'(IDLE));
    reset = 1'b1;
    for (int c = 0; c < 18; c++) begin
      check($sformatf("scan_en_c%0d", c), 8'(kif.scan_en), 8'((c % 4) == 3));
      check($sformatf("disp_sel_c%0d", c), 8'(kif.disp_sel), 8'((c / 8) % 2));
      @(negedge clk);
    end

    // 2. clean press of 5
    base = pulse_cnt;
    tick_drive(1'b1, KEY_5, 1'b1);
    @(negedge clk);
    check("p5_state_db", 8'(kif.state), 8'(DEBOUNCE));
    tick_drive(1'b0, KEY_5, 1'b1);
    tick_drive(1'b0, KEY_5, 1'b1);
    tick_drive(1'b0, KEY_5, 1'b1);
    @(negedge clk);
    check("p5_state_commit", 8'(kif.state),     8'(COMMIT));
    check("p5_new_digit",    8'(kif.new_digit), 8'h1);
    check("p5_digit_r",      8'(kif.digit_r),   8'h5);
    check("p5_digit_l",      8'(kif.digit_l),   8'h0);
    @(negedge clk);
    check("p5_new_digit_low", 8'(kif.new_digit), 8'h0);
    check("p5_state_wait",    8'(kif.state),     8'(WAIT_REL));
    for (int i = 0; i < 3; i++) tick_drive(1'b0, KEY_5, 1'b1);
    release_key(2);
    @(negedge clk);
    check("p5_state_rel2", 8'(kif.state), 8'(WAIT_REL));
    release_key(1);
    @(negedge clk);
    check("p5_state_idle", 8'(kif.state), 8'(IDLE));
    check("p5_pulses",     8'(pulse_cnt - base), 8'h1);

    // 3. bounce on 9
    base = pulse_cnt;
    press(KEY_9, 1);
    release_key(1);
    @(negedge clk);
    check("b9_state",   8'(kif.state),   8'(IDLE));
    check("b9_digit_r", 8'(kif.digit_r), 8'h5);
    check("b9_digit_l", 8'(kif.digit_l), 8'h0);
    check("b9_pulses",  8'(pulse_cnt - base), 8'h0);

    // 4. presses 3 then A
    base = pulse_cnt;
    press(KEY_3, 3);
    release_key(3);
    press(KEY_A, 3);
    release_key(3);
    @(negedge clk);
    check("p3a_digit_l", 8'(kif.digit_l), 8'h3);
    check("p3a_digit_r", 8'(kif.digit_r), 8'hA);
    check("p3a_pulses",  8'(pulse_cnt - base), 8'h2);
    wait_sel(1'b0);
    check("p3a_seg_sel0", 8'(kif.seg_hex), 8'hA);
    wait_sel(1'b1);
    check("p3a_seg_sel1", 8'(kif.seg_hex), 8'h3);

    // 5. release glitch on C, key_valid during glitch ignored
    base = pulse_cnt;
    press(KEY_C, 3);
    release_key(2);
    tick_drive(1'b1, KEY_E, 1'b1);
    @(negedge clk);
    check("gl_state_glitch", 8'(kif.state), 8'(WAIT_REL));
    release_key(2);
    @(negedge clk);
    check("gl_state_rel2", 8'(kif.state), 8'(WAIT_REL));
    release_key(1);
    @(negedge clk);
    check("gl_state_idle", 8'(kif.state),   8'(IDLE));
    check("gl_digit_l",    8'(kif.digit_l), 8'hA);
    check("gl_digit_r",    8'(kif.digit_r), 8'hC);
    check("gl_pulses",     8'(pulse_cnt - base), 8'h1);

    // 6. long hold of 7, then reset mid-debounce on a second press
    base = pulse_cnt;
    press(KEY_7, 500);
`ifdef KEYPAD_REPEAT_EN
    exp_pulses = 3;
    @(negedge clk);
    check("h7_digit_l", 8'(kif.digit_l), 8'h7);
`else
    exp_pulses = 1;
    @(negedge clk);
    check("h7_digit_l", 8'(kif.digit_l), 8'hC);
`endif
    check("h7_digit_r", 8'(kif.digit_r), 8'h7);
    check("h7_pulses",  8'(pulse_cnt - base), 8'(exp_pulses));
    release_key(3);
    @(negedge clk);
    check("h7_state_idle", 8'(kif.state), 8'(IDLE));
    base = pulse_cnt;
    press(KEY_7, 1);
    @(negedge clk);
    check("r7_state_db", 8'(kif.state), 8'(DEBOUNCE));
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("r7_digit_l",  8'(kif.digit_l),   8'h0);
    check("r7_digit_r",  8'(kif.digit_r),   8'h0);
    check("r7_seg_hex",  8'(kif.seg_hex),   8'h0);
    check("r7_state",    8'(kif.state),     8'(IDLE));
    for (int i = 0; i < 4; i++) tick_drive(1'b0, KEY_7, 1'b1);
    @(negedge clk);
    check("r7_state_after", 8'(kif.state),   8'(IDLE));
    check("r7_digit_r_after", 8'(kif.digit_r), 8'h0);
    check("r7_pulses",      8'(pulse_cnt - base), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
